// File: rtl/fpmul_result_queue.sv
// fpmul_result_queue: registered FWFT result queue behind the FP multiplier
//   with sticky exception/overflow/underflow status and a saturating result count.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     producer handshake; in_result + in_exception/overflow/underflow payload
//   out_valid/out_ready   consumer handshake; out_result + out_flags {exc, ovf, unf} of head entry
//   clr_sticky            pulse clearing sticky_flags and op_count (a same-cycle push wins)
//   sticky_flags          OR of flags of all accepted words since clear/reset
//   op_count              saturating count of accepted words since clear/reset
module fpmul_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_exception,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    input  logic             clr_sticky,
    output logic [2:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   mem_result [DEPTH];
    logic [2:0]    mem_flags  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic [2:0]    in_flags;
    logic          push, pop;

    assign in_flags   = {in_exception, in_overflow, in_underflow};
    // Handshake readiness is purely a function of registered occupancy.
    assign in_ready   = occ != FULL;
    assign out_valid  = occ != '0;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_result = out_valid ? mem_result[rd_ptr] : '0;
    assign out_flags  = out_valid ? mem_flags[rd_ptr] : '0;

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            sticky_flags <= '0;
            op_count     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            occ <= (push && !pop) ? occ + (PW+1)'(1) : (!push && pop) ? occ - (PW+1)'(1) : occ;
            // A push in the clearing cycle survives the clear.
            sticky_flags <= clr_sticky ? (push ? in_flags : 3'b000)
                                       : (push ? sticky_flags | in_flags : sticky_flags);
            op_count <= clr_sticky ? (push ? CNT_W'(1) : '0)
                                   : (push && !(&op_count)) ? op_count + CNT_W'(1) : op_count;
        end
    end
endmodule
